// File: rtl/fde_pkg.sv
// rtl/fde_pkg.sv - shared definitions for the FDE CPU controller and execute unit
// Purpose: opcode encodings, controller state encoding, instruction field
//          positions and the default instruction width.
// Ports:   none (package)
package fde_pkg;

  localparam int INSTR_W_DEF = 16;

  // Instruction field bit positions: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DST_MSB  = 11;
  localparam int DST_LSB  = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_MSB = 3;
  localparam int SRC2_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LS   = 4'b0100;
  localparam logic [3:0] OP_RS   = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  // Result-producing opcodes; these are the only ones that get a writeback.
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LS) || (op == OP_RS);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_alu(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/fde_if.sv
// rtl/fde_if.sv - instruction-memory fetch handshake interface
// Purpose: groups the req/valid fetch bus between controller and imem.
// Signals: imem_req   - fetch request, held until accepted
//          imem_addr  - fetch address, stable while imem_req is high
//          imem_valid - instruction data valid
//          imem_data  - instruction word
// Modports: master (controller side), slave (memory side)
interface fde_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/fde_pc.sv
// rtl/fde_pc.sv - program counter with load, increment and hold
// Purpose: PC register; load has priority over increment, wraps modulo 2^PC_W.
// Ports:   clk, rst (async active-high), load + load_val, inc, pc (current value)
module fde_pc #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fde_controller.sv
// rtl/fde_controller.sv - fetch/decode/execute/writeback sequencer for the FDE CPU
// Purpose: owns PC, IR and the FSM; fetches over the imem handshake, drives
//          register-file read addresses, execute opcode and the write strobe.
// Ports:   i_clk, i_reset (async active-high), i_start, i_start_pc,
//          imem (fde_if.master fetch bus), o_rd_add1, o_rd_add2, o_opcode,
//          o_write_en, o_write_add, o_pc, o_busy, o_halted, o_illegal
module fde_controller
  import fde_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [PC_W-1:0] i_start_pc,
  fde_if.master           imem,
  output logic [3:0]      o_rd_add1,
  output logic [3:0]      o_rd_add2,
  output logic [3:0]      o_opcode,
  output logic            o_write_en,
  output logic [3:0]      o_write_add,
  output logic [PC_W-1:0] o_pc,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_illegal
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic               illegal;
  logic               pc_load, pc_inc, ir_load, illegal_set, illegal_clr;
  logic [3:0]         opc;

  assign opc = ir[OPC_MSB:OPC_LSB];

  fde_pc #(.PC_W(PC_W)) u_pc (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (pc_load),
    .load_val (i_start_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign imem.imem_addr = pc;
  assign o_pc           = pc;
  assign o_illegal      = illegal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        ir <= imem.imem_data;
      end
      // Clear and set never coincide: clear happens only on start from IDLE/HALTED.
      if (illegal_clr) begin
        illegal <= 1'b0;
      end else if (illegal_set) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    ir_load       = 1'b0;
    illegal_set   = 1'b0;
    illegal_clr   = 1'b0;
    imem.imem_req = 1'b0;
    o_rd_add1     = 4'h0;
    o_rd_add2     = 4'h0;
    o_opcode      = 4'h0;
    o_write_en    = 1'b0;
    o_write_add   = 4'h0;
    o_busy        = 1'b0;
    o_halted      = 1'b0;

    case (state)
      ST_IDLE, ST_HALTED: begin
        // Memory responses arriving here are ignored: no req, no IR load.
        o_halted = (state == ST_HALTED);
        if (i_start) begin
          state_nxt   = ST_FETCH;
          pc_load     = 1'b1;
          illegal_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        o_busy        = 1'b1;
        imem.imem_req = 1'b1;
        if (imem.imem_valid) begin
          ir_load   = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        o_busy    = 1'b1;
        o_rd_add1 = ir[SRC1_MSB:SRC1_LSB];
        o_rd_add2 = ir[SRC2_MSB:SRC2_LSB];
        state_nxt = (opc == OP_HALT) ? ST_HALTED : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        o_busy    = 1'b1;
        o_rd_add1 = ir[SRC1_MSB:SRC1_LSB];
        o_rd_add2 = ir[SRC2_MSB:SRC2_LSB];
        o_opcode  = opc;
        if (is_alu(opc)) begin
          state_nxt = ST_WRITEBACK;
        end else begin
          state_nxt   = ST_FETCH;
          pc_inc      = 1'b1;
          illegal_set = !is_legal(opc);
        end
      end
      ST_WRITEBACK: begin
        // Always leaves after one cycle, so the strobe can never repeat back-to-back.
        o_busy      = 1'b1;
        o_rd_add1   = ir[SRC1_MSB:SRC1_LSB];
        o_rd_add2   = ir[SRC2_MSB:SRC2_LSB];
        o_opcode    = opc;
        o_write_en  = 1'b1;
        o_write_add = ir[DST_MSB:DST_LSB];
        pc_inc      = 1'b1;
        state_nxt   = ST_FETCH;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fde_controller.sv
// tb/tb_fde_controller.sv - self-checking bench for fde_controller
module tb_fde_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_pc;
  logic [3:0]  rd1, rd2, opc, wadd;
  logic        wen;
  logic [7:0]  pc;
  logic        busy, halted, illegal;

  int ncmp = 0;
  int nerr = 0;

  logic [15:0] prog [4];

  fde_if #(.PC_W(8), .INSTR_W(16)) imem ();

  always #5 clk = ~clk;

  fde_controller #(.PC_W(8), .INSTR_W(16)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_start_pc  (start_pc),
    .imem        (imem),
    .o_rd_add1   (rd1),
    .o_rd_add2   (rd2),
    .o_opcode    (opc),
    .o_write_en  (wen),
    .o_write_add (wadd),
    .o_pc        (pc),
    .o_busy      (busy),
    .o_halted    (halted),
    .o_illegal   (illegal)
  );

  typedef struct {
    logic [7:0]  spc;
    logic [15:0] instr;
    int          waits;
    logic [3:0]  e_rd1;
    logic [3:0]  e_rd2;
    logic [3:0]  e_opc;
    int          e_wr;
    int          e_wcyc;
    logic [3:0]  e_wadd;
    logic [7:0]  e_pc;
    logic        e_ill;
    logic        e_halt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    start_pc = 8'h00;
    imem.imem_valid = 1'b0;
    imem.imem_data = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1;
    start_pc = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int req_n = 0;
    int wr_n = 0;
    int wcyc = 0;
    logic addr_ok = 1'b1;
    logic accepted = 1'b0;
    logic [3:0] x1 = 4'h0, x2 = 4'h0, xo = 4'h0, xw = 4'h0;
    do_reset();
    pulse_start(v.spc);
    for (int c = 1; c <= v.waits + 6; c++) begin
      if (imem.imem_req && !accepted) begin
        req_n++;
        if (imem.imem_addr !== v.spc) addr_ok = 1'b0;
      end
      if (c == v.waits + 3) begin
        x1 = rd1;
        x2 = rd2;
        xo = opc;
      end
      if (wen) begin
        wr_n++;
        wcyc = c;
        xw = wadd;
      end
      if (imem.imem_req && !accepted && c > v.waits) begin
        imem.imem_valid = 1'b1;
        imem.imem_data = v.instr;
        accepted = 1'b1;
      end else begin
        imem.imem_valid = 1'b0;
        imem.imem_data = 16'h0000;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d req_cycles", idx), req_n, v.waits + 1);
    check($sformatf("v%0d addr_stable", idx), {31'b0, addr_ok}, 1);
    check($sformatf("v%0d rd_add1", idx), {28'b0, x1}, {28'b0, v.e_rd1});
    check($sformatf("v%0d rd_add2", idx), {28'b0, x2}, {28'b0, v.e_rd2});
    check($sformatf("v%0d opcode", idx), {28'b0, xo}, {28'b0, v.e_opc});
    check($sformatf("v%0d write_count", idx), wr_n, v.e_wr);
    if (v.e_wr != 0) begin
      check($sformatf("v%0d write_cycle", idx), wcyc, v.e_wcyc);
      check($sformatf("v%0d write_add", idx), {28'b0, xw}, {28'b0, v.e_wadd});
    end
    check($sformatf("v%0d pc", idx), {24'b0, pc}, {24'b0, v.e_pc});
    check($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.e_ill});
    check($sformatf("v%0d halted", idx), {31'b0, halted}, {31'b0, v.e_halt});
  endtask

  // Serve prog[] as a zero-wait memory until HALTED or the cycle budget runs out.
  task automatic run_to_halt(output int wr_n, output int consec, output logic done);
    logic prev_wen = 1'b0;
    wr_n = 0;
    consec = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wen) wr_n++;
      if (wen && prev_wen) consec++;
      prev_wen = wen;
      if (halted) begin
        done = 1'b1;
        break;
      end
      imem.imem_valid = imem.imem_req;
      imem.imem_data = prog[imem.imem_addr[1:0]];
      @(negedge clk);
    end
    imem.imem_valid = 1'b0;
    imem.imem_data = 16'h0000;
  endtask

  initial begin
    int wr_n, consec;
    logic done;

    rst = 1'b1;
    start = 1'b0;
    start_pc = 8'h00;
    imem.imem_valid = 1'b0;
    imem.imem_data = 16'h0000;

    //           spc    instr    w  rd1  rd2  opc  wr wcyc wadd  pc    ill   halt
    vecs[0] = '{8'h10, 16'h1312, 0, 4'h1, 4'h2, 4'h1, 1, 4, 4'h3, 8'h11, 1'b0, 1'b0};
    vecs[1] = '{8'h20, 16'h2A5F, 3, 4'h5, 4'hF, 4'h2, 1, 7, 4'hA, 8'h21, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 16'h4C01, 0, 4'h0, 4'h1, 4'h4, 1, 4, 4'hC, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 16'h0123, 1, 4'h2, 4'h3, 4'h0, 0, 0, 4'h0, 8'h06, 1'b0, 1'b0};
    vecs[4] = '{8'h30, 16'h3456, 0, 4'h5, 4'h6, 4'h3, 0, 0, 4'h0, 8'h31, 1'b1, 1'b0};
    vecs[5] = '{8'h40, 16'hF000, 2, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 8'h40, 1'b0, 1'b1};
    vecs[6] = '{8'h50, 16'h8E9A, 0, 4'h9, 4'hA, 4'h8, 1, 4, 4'hE, 8'h51, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, busy}, 0);
    check("rst halted", {31'b0, halted}, 0);
    check("rst illegal", {31'b0, illegal}, 0);
    check("rst req", {31'b0, imem.imem_req}, 0);
    check("rst write_en", {31'b0, wen}, 0);
    check("rst pc", {24'b0, pc}, 0);
    check("rst addr", {24'b0, imem.imem_addr}, 0);
    check("rst opcode", {28'b0, opc}, 0);
    check("rst rd_add1", {28'b0, rd1}, 0);
    check("rst write_add", {28'b0, wadd}, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // SUB, NOP, HALT program at 0x00..0x02
    do_reset();
    prog[0] = 16'h2312;
    prog[1] = 16'h0000;
    prog[2] = 16'hF000;
    prog[3] = 16'h0000;
    pulse_start(8'h00);
    run_to_halt(wr_n, consec, done);
    check("prog reached_halt", {31'b0, done}, 1);
    check("prog write_count", wr_n, 1);
    check("prog consecutive_we", consec, 0);
    check("prog halt_pc", {24'b0, pc}, 8'h02);
    check("prog busy_in_halt", {31'b0, busy}, 0);
    wr_n = 0;
    for (int c = 0; c < 3; c++) begin
      imem.imem_valid = 1'b1;
      imem.imem_data = 16'h1312;
      @(negedge clk);
      if (wen) wr_n++;
    end
    imem.imem_valid = 1'b0;
    check("halt ignores_valid writes", wr_n, 0);
    check("halt ignores_valid pc", {24'b0, pc}, 8'h02);
    check("halt ignores_valid halted", {31'b0, halted}, 1);

    // Illegal opcode stays flagged through HALT, cleared by the next start
    do_reset();
    prog[0] = 16'h3000;
    prog[1] = 16'hF000;
    pulse_start(8'h00);
    run_to_halt(wr_n, consec, done);
    check("ill reached_halt", {31'b0, done}, 1);
    check("ill write_count", wr_n, 0);
    check("ill sticky", {31'b0, illegal}, 1);
    check("ill halt_pc", {24'b0, pc}, 8'h01);
    pulse_start(8'h02);
    check("ill cleared_on_start", {31'b0, illegal}, 0);
    check("restart req", {31'b0, imem.imem_req}, 1);
    check("restart addr", {24'b0, imem.imem_addr}, 8'h02);
    // start while busy must not reload the PC
    start = 1'b1;
    start_pc = 8'h80;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("start_while_busy addr", {24'b0, imem.imem_addr}, 8'h02);

    // Async reset during a FETCH wait, then a late response
    do_reset();
    pulse_start(8'h10);
    @(negedge clk);
    check("midfetch req", {31'b0, imem.imem_req}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst req", {31'b0, imem.imem_req}, 0);
    check("async_rst busy", {31'b0, busy}, 0);
    check("async_rst pc", {24'b0, pc}, 0);
    @(negedge clk);
    rst = 1'b0;
    imem.imem_valid = 1'b1;
    imem.imem_data = 16'h1312;
    repeat (3) @(negedge clk);
    imem.imem_valid = 1'b0;
    check("late_valid busy", {31'b0, busy}, 0);
    check("late_valid rd_add1", {28'b0, rd1}, 0);
    check("late_valid write_en", {31'b0, wen}, 0);
    check("late_valid pc", {24'b0, pc}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
